// File: rtl/display_word_queue_pkg.sv
// rtl/display_word_queue_pkg.sv - word/digit widths and leading-zero helper shared with the scan driver
package disp_pkg;

  localparam int WORD_W        = 16;
  localparam int NIBBLE_W      = 4;
  localparam int DIGITS        = 4;
  localparam int DWELL_DEFAULT = 50_000_000;

  typedef logic [NIBBLE_W-1:0] digit_t;
  typedef logic [WORD_W-1:0]   word_t;

  localparam logic [DIGITS-1:0] BLANK_RESET = 4'b0111;

  // Bit i set when digits 0..i are all zero; the rightmost digit always shows.
  function automatic logic [DIGITS-1:0] leading_zero_mask(input word_t w);
    logic [DIGITS-1:0] m;
    logic              zero_run;
    digit_t            d;
    m        = '0;
    zero_run = 1'b1;
    for (int i = 0; i < DIGITS - 1; i++) begin
      d        = w[WORD_W-1-i*NIBBLE_W -: NIBBLE_W];
      zero_run = zero_run && (d == '0);
      m[i]     = zero_run;
    end
    return m;
  endfunction

endpackage

// File: rtl/display_word_queue_if.sv
// rtl/display_word_queue_if.sv - producer and display-side signals of the word queue (DISPLAY_WORD_QUEUE_BLANK_EN adds blank_mask)
interface display_word_queue_if #(
  parameter int DEPTH = 8
);
  import disp_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  word_t            in_data;
  logic             in_ready;
  logic             clear;
  word_t            show_word;
  logic             show_valid;
  logic [CNT_W-1:0] count;
  logic [7:0]       retired;
  logic             overflow;
`ifdef DISPLAY_WORD_QUEUE_BLANK_EN
  logic [DIGITS-1:0] blank_mask;
`endif

  modport master (
    output in_valid, in_data, clear,
`ifdef DISPLAY_WORD_QUEUE_BLANK_EN
    input  blank_mask,
`endif
    input  in_ready, show_word, show_valid, count, retired, overflow
  );

  modport slave (
    input  in_valid, in_data, clear,
`ifdef DISPLAY_WORD_QUEUE_BLANK_EN
    output blank_mask,
`endif
    output in_ready, show_word, show_valid, count, retired, overflow
  );

endinterface

// File: rtl/display_word_queue_dwell_timer.sv
// rtl/display_word_queue_dwell_timer.sv - counts display dwell and pulses expire on the last cycle
module dwell_timer #(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic expire
);

  localparam int CNT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             at_last;

  assign at_last = (cnt == LAST);
  assign expire  = run && at_last && !restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= at_last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_word_queue.sv
// rtl/display_word_queue.sv - FIFO of display words, each held for a dwell period; last word stays shown
// Optional leading-zero blanking output under DISPLAY_WORD_QUEUE_BLANK_EN.
module display_word_queue
  import disp_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int DWELL_CYCLES = DWELL_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  display_word_queue_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  word_t            mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CNT_W-1:0] count_q;
  word_t            show_word_q;
  logic             show_valid_q;
  logic [7:0]       retired_q;
  logic             overflow_q;

  logic  push;
  logic  pop;
  logic  expire;
  logic  load_empty;
  word_t next_word;

  assign bus.in_ready = (count_q != FULL) && !bus.clear;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = expire && (count_q >= CNT_W'(2));
  assign load_empty   = push && (count_q == '0);
  assign next_word    = mem[rd_ptr + AW'(1)];

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (show_valid_q),
    .restart(bus.clear || load_empty),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // The head entry is mirrored in show_word_q; a pop moves the mirror to the next slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count_q      <= '0;
      show_word_q  <= '0;
      show_valid_q <= 1'b0;
      retired_q    <= '0;
      overflow_q   <= 1'b0;
    end else if (bus.clear) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count_q      <= '0;
      show_word_q  <= '0;
      show_valid_q <= 1'b0;
      retired_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        retired_q <= retired_q + 8'd1;
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (load_empty) begin
        show_word_q  <= bus.in_data;
        show_valid_q <= 1'b1;
      end else if (pop) begin
        show_word_q <= next_word;
      end
      if (bus.in_valid && !bus.in_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef DISPLAY_WORD_QUEUE_BLANK_EN
  logic [DIGITS-1:0] blank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= BLANK_RESET;
    end else if (bus.clear) begin
      blank_q <= BLANK_RESET;
    end else if (load_empty) begin
      blank_q <= leading_zero_mask(bus.in_data);
    end else if (pop) begin
      blank_q <= leading_zero_mask(next_word);
    end
  end

  assign bus.blank_mask = blank_q;
`endif

  assign bus.show_word  = show_word_q;
  assign bus.show_valid = show_valid_q;
  assign bus.count      = count_q;
  assign bus.retired    = retired_q;
  assign bus.overflow   = overflow_q;

endmodule
